// File: rtl/ethernet_pkg.sv
// ethernet_pkg
// Shared types and constants for the Ethernet TX packet buffer.
//   tx_state_e  : transmit FSM states (idle / fetch word / stream bytes / done)
//   op_size_e   : CPU write size encoding (0=byte, 1=half, 2=word)
//   ETH_MIN_FRAME_BYTES : minimum frame length used when padding is enabled
//                         (ETHERNET_TX_PAD_EN)
//   lane_mask() : byte-lane write mask for a write of a given size at a lane
//   is_aligned(): natural-alignment check for a write of a given size
package ethernet_pkg;

    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_FETCH  = 2'd1,
        TX_STREAM = 2'd2,
        TX_DONE   = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        OP_BYTE = 2'd0,
        OP_HALF = 2'd1,
        OP_WORD = 2'd2
    } op_size_e;

    localparam int ETH_MIN_FRAME_BYTES = 60;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] mask;
        mask = 4'b0000;
        if (size == OP_BYTE) begin
            mask = 4'b0001 << lane;
        end else if (size == OP_HALF) begin
            mask = 4'b0011 << lane;
        end else if (size == OP_WORD) begin
            mask = 4'b1111;
        end
        return mask;
    endfunction

    // Size code 3 has no meaning and is treated as never aligned.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
        logic ok;
        ok = 1'b0;
        if (size == OP_BYTE) begin
            ok = 1'b1;
        end else if (size == OP_HALF) begin
            ok = ~lane[0];
        end else if (size == OP_WORD) begin
            ok = (lane == 2'b00);
        end
        return ok;
    endfunction

endpackage

// File: rtl/ethernet_tx_buffer_mem.sv
// ethernet_tx_buffer_mem
// Single-port synchronous RAM holding the packet, organised as 32-bit words
// with per-byte write enables. Contents are not reset. The read port is
// registered: data for a read issued in cycle N appears on data_o in N+1 and
// holds until the next read. The parent never reads and writes in one cycle.
// Ports:
//   clk_i   in   clock
//   w_i     in   write enable (bytes selected by mask_i)
//   r_i     in   read enable
//   addr_i  in   word address
//   data_i  in   write data, byte lanes aligned to the word
//   mask_i  in   byte write mask
//   data_o  out  registered read data
module ethernet_tx_buffer_mem
    import ethernet_pkg::*;
#(
    parameter int els_p        = 512,
    parameter int addr_width_p = 9
) (
    input  logic                    clk_i,
    input  logic                    w_i,
    input  logic                    r_i,
    input  logic [addr_width_p-1:0] addr_i,
    input  logic [31:0]             data_i,
    input  logic [3:0]              mask_i,
    output logic [31:0]             data_o
);

    logic [31:0] mem [els_p];
    logic [31:0] data_q;
    logic [31:0] data_d;

    // Read data register only updates on a read so the streamed word stays put
    always_comb begin
        data_d = data_q;
        if (r_i) begin
            data_d = mem[addr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_i) begin
            for (int i = 0; i < 4; i++) begin
                if (mask_i[i]) begin
                    mem[addr_i][8*i +: 8] <= data_i[8*i +: 8];
                end
            end
        end
        data_q <= data_d;
    end

    assign data_o = data_q;

endmodule

// File: rtl/ethernet_tx_buffer.sv
// ethernet_tx_buffer
// One-slot TX packet buffer. The CPU writes the packet with byte/half/word
// stores and latches its length while the buffer is idle; a send pulse then
// streams the packet byte by byte to the MAC with valid/ready handshaking.
// Completion sets a pending flag that drives the TX interrupt.
// Optional build macro: ETHERNET_TX_PAD_EN -- frames shorter than
// ETH_MIN_FRAME_BYTES are padded with zero bytes up to that length.
// Ports:
//   clk_i / reset_n_i            clock, async active-low reset
//   packet_send_i                start transmission (pulse)
//   packet_req_o                 buffer idle, accepting writes/send
//   packet_wsize_valid_i/_i      latch packet length (clamped to eth_mtu_p)
//   packet_wvalid_i, _waddr_i,
//   _wdata_i, _wdata_size_i      CPU write (LSB-justified data, size 0/1/2)
//   tx_data_o/valid_o/last_o     byte stream to MAC, tx_ready_i accepts
//   tx_interrupt_clear_i         clear pending
//   tx_interrupt_enable_i/_v_i   interrupt enable write
//   tx_interrupt_pending_o       TX completion pending
//   tx_irq_o                     pending & enable
//   write_drop_o                 pulse: a write/size/send was rejected
module ethernet_tx_buffer
    import ethernet_pkg::*;
#(
    parameter  int eth_mtu_p            = 2048,
    parameter  int data_width_p         = 32,
    localparam int size_width_lp        = $clog2($clog2(data_width_p/8) + 1),
    localparam int packet_size_width_lp = $clog2(eth_mtu_p + 1),
    localparam int packet_addr_width_lp = $clog2(eth_mtu_p)
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic                            packet_send_i,
    output logic                            packet_req_o,
    input  logic                            packet_wsize_valid_i,
    input  logic [packet_size_width_lp-1:0] packet_wsize_i,
    input  logic                            packet_wvalid_i,
    input  logic [packet_addr_width_lp-1:0] packet_waddr_i,
    input  logic [data_width_p-1:0]         packet_wdata_i,
    input  logic [size_width_lp-1:0]        packet_wdata_size_i,
    output logic [7:0]                      tx_data_o,
    output logic                            tx_valid_o,
    output logic                            tx_last_o,
    input  logic                            tx_ready_i,
    input  logic                            tx_interrupt_clear_i,
    input  logic                            tx_interrupt_enable_i,
    input  logic                            tx_interrupt_enable_v_i,
    output logic                            tx_interrupt_pending_o,
    output logic                            tx_irq_o,
    output logic                            write_drop_o
);

    localparam int sw_lp        = packet_size_width_lp;
    localparam int word_aw_lp   = packet_addr_width_lp - 2;
    localparam int mem_els_lp   = eth_mtu_p / 4;
    localparam logic [sw_lp-1:0] mtu_len_lp = sw_lp'(eth_mtu_p);

    tx_state_e         state_q, state_d;
    logic [sw_lp-1:0]  size_q, size_d;
    logic [sw_lp-1:0]  byte_cnt_q, byte_cnt_d;
    logic              pending_q, pending_d;
    logic              enable_q, enable_d;
    logic              drop_q, drop_d;

    logic [sw_lp-1:0]  eff_len;
    logic              pad_byte;
    logic [1:0]        lane;
    logic              mem_w, mem_r;
    logic [word_aw_lp-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_mask;
    logic [31:0]       mem_rdata;

    assign lane = byte_cnt_q[1:0];

    // Bytes past the stored length are padding: they are emitted as zero and
    // their words never need to come from memory.
`ifdef ETHERNET_TX_PAD_EN
    localparam logic [sw_lp-1:0] min_len_lp = sw_lp'(ETH_MIN_FRAME_BYTES);
    assign eff_len  = (size_q < min_len_lp) ? min_len_lp : size_q;
    assign pad_byte = (byte_cnt_q >= size_q);
`else
    assign eff_len  = size_q;
    assign pad_byte = 1'b0;
`endif

    // The single RAM port is shared: CPU writes own it in IDLE, the stream
    // read owns it otherwise.
    assign mem_addr  = (state_q == TX_IDLE) ? packet_waddr_i[packet_addr_width_lp-1:2]
                                            : byte_cnt_q[packet_addr_width_lp-1:2];
    assign mem_wdata = packet_wdata_i << {packet_waddr_i[1:0], 3'b000};
    assign mem_mask  = lane_mask(packet_wdata_size_i, packet_waddr_i[1:0]);

    ethernet_tx_buffer_mem #(
        .els_p        (mem_els_lp),
        .addr_width_p (word_aw_lp)
    ) mem_u (
        .clk_i  (clk_i),
        .w_i    (mem_w),
        .r_i    (mem_r),
        .addr_i (mem_addr),
        .data_i (mem_wdata),
        .mask_i (mem_mask),
        .data_o (mem_rdata)
    );

    // Next-state, stream outputs and CPU-side acceptance in one place so the
    // state gating of writes and reads is easy to see.
    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        byte_cnt_d   = byte_cnt_q;
        drop_d       = 1'b0;
        mem_w        = 1'b0;
        mem_r        = 1'b0;
        packet_req_o = 1'b0;
        tx_valid_o   = 1'b0;
        tx_last_o    = 1'b0;
        tx_data_o    = 8'h00;

        case (state_q)
            TX_IDLE: begin
                packet_req_o = 1'b1;
                if (packet_wvalid_i) begin
                    if (is_aligned(packet_wdata_size_i, packet_waddr_i[1:0])) begin
                        mem_w = 1'b1;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
                if (packet_wsize_valid_i) begin
                    size_d = (packet_wsize_i > mtu_len_lp) ? mtu_len_lp : packet_wsize_i;
                end
                if (packet_send_i) begin
                    byte_cnt_d = '0;
                    state_d    = (eff_len != '0) ? TX_FETCH : TX_DONE;
                end
            end
            TX_FETCH: begin
                mem_r   = ~pad_byte;
                state_d = TX_STREAM;
            end
            TX_STREAM: begin
                tx_valid_o = 1'b1;
                tx_data_o  = pad_byte ? 8'h00 : mem_rdata[{lane, 3'b000} +: 8];
                tx_last_o  = (byte_cnt_q == eff_len - sw_lp'(1));
                if (tx_ready_i) begin
                    if (tx_last_o) begin
                        byte_cnt_d = '0;
                        state_d    = TX_DONE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + sw_lp'(1);
                        if (lane == 2'd3) begin
                            state_d = TX_FETCH;
                        end
                    end
                end
            end
            TX_DONE: begin
                state_d = TX_IDLE;
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase

        if ((state_q != TX_IDLE) &&
            (packet_wvalid_i || packet_wsize_valid_i || packet_send_i)) begin
            drop_d = 1'b1;
        end
    end

    // Completion wins over a simultaneous clear so no TX event is lost.
    always_comb begin
        pending_d = pending_q;
        enable_d  = enable_q;
        if (state_q == TX_DONE) begin
            pending_d = 1'b1;
        end else if (tx_interrupt_clear_i) begin
            pending_d = 1'b0;
        end
        if (tx_interrupt_enable_v_i) begin
            enable_d = tx_interrupt_enable_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= TX_IDLE;
            size_q     <= '0;
            byte_cnt_q <= '0;
            pending_q  <= 1'b0;
            enable_q   <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            byte_cnt_q <= byte_cnt_d;
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            drop_q     <= drop_d;
        end
    end

    assign tx_interrupt_pending_o = pending_q;
    assign tx_irq_o               = pending_q & enable_q;
    assign write_drop_o           = drop_q;

endmodule
